// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and width default for the multiply/divide sequencer.
// Divide support in the RTL is selected by the MDU_DIV_EN macro.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step on the {hi,lo} accumulator: shift-add multiply or restoring divide, purely combinational.
// The divide step exists only when MDU_DIV_EN is defined; otherwise a divide select yields zero.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;

  // Carry out of the upper add becomes the new MSB after the right shift.
  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_mul_nxt = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_trial;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Remainder is kept below the divisor, so the shifted value needs one extra bit.
  assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial   = {1'b0, w_rem_sh} - {2'b00, i_opnd};
  assign w_div_nxt = w_trial[WIDTH+1] ? {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0],  i_acc[WIDTH-2:0], 1'b1};
  assign o_acc     = i_div ? w_div_nxt : w_mul_nxt;
`else
  assign o_acc     = w_mul_nxt & {(2*WIDTH){~i_div}};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: WIDTH iterations in RUN, one-cycle HI/LO strobe in DONE (accept-to-strobe WIDTH+1).
// Define MDU_DIV_EN for the divide datapath; without it DIV/DIVU are refused and pulse illegal_op.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic               w_op_ok;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;

  assign w_signed = ~op[0];
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_sa ? -a : a;
  assign w_abs_b  = w_sb ? -b : b;

  assign ready        = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = start && !flush && ready && w_op_ok;
  assign w_last       = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH-1));
  assign stall        = (mf_req && busy) || (start && w_op_ok && (r_state == ST_RUN));
  assign result_valid = (r_state == ST_DONE) && !flush;
  assign result_hi    = r_hi;
  assign result_lo    = r_lo;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt)
  );

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;

`ifdef MDU_DIV_EN
  logic             r_neg_r;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_op_ok    = 1'b1;
  assign w_quo      = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_rem      = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_res      = r_div ? {w_rem, w_quo} : w_prod;
  assign illegal_op = 1'b0;

  // Remainder follows the dividend's sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_r <= w_sa;
    end
  end
`else
  logic r_illegal;

  assign w_op_ok    = ~op[1];
  assign w_res      = w_prod;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= start && !flush && ready && !w_op_ok;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= ST_DONE;
              r_hi    <= w_res[2*WIDTH-1:WIDTH];
              r_lo    <= w_res[WIDTH-1:0];
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_div   <= op[1];
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            r_neg_q <= (w_sa ^ w_sb) && (b != '0);
            r_opnd  <= op[1] ? w_abs_b : w_abs_a;
            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: expected HI/LO pairs queued at request time, popped at each strobe, plus cycle-exact control checks.
// Define MDU_DIV_EN for both bench and RTL to cover the divide path; otherwise the refused-divide path is covered.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mf_req = 1'b0;
  logic        flush = 1'b0;
  logic        ready;
  logic        busy;
  logic        stall;
  logic        result_valid;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        illegal_op;

  int          ncmp = 0;
  int          nerr = 0;
  res_t        exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .mf_req       (mf_req),
    .flush        (flush),
    .ready        (ready),
    .busy         (busy),
    .stall        (stall),
    .result_valid (result_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [63:0] p;
    r = '0;
    p = '0;
    case (o)
      MDU_MULT: begin
        p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
        r = res_t'(p);
      end
      MDU_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        r = res_t'(p);
      end
      MDU_DIV: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.hi = 32'd0; r.lo = 32'h8000_0000;
        end else begin
          r.lo = $signed(x) / $signed(y);
          r.hi = $signed(x) % $signed(y);
        end
      end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF;
        end else begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  function automatic res_t pop_exp();
    res_t r;
    r = '0;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    last_hi = r.hi;
    last_lo = r.lo;
    return r;
  endfunction

  // Called at the drive point (1 time unit after a rising edge); returns at the drive point of the next cycle.
  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accepting edge; at_c is -1 if no strobe within the budget.
  task automatic wait_strobe(output int at_c, output logic [31:0] hi, output logic [31:0] lo);
    bit done;
    done = 1'b0; at_c = -1; hi = '0; lo = '0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        at_c = c; hi = result_hi; lo = result_lo; done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    ncmp++; if (ready !== 1'b1)        begin nerr++; $display("FAIL reset_ready got %b want 1", ready); end
    ncmp++; if (stall !== 1'b0)        begin nerr++; $display("FAIL reset_stall got %b want 0", stall); end
    ncmp++; if (result_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", result_valid); end
    ncmp++; if (illegal_op !== 1'b0)   begin nerr++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    ncmp++; if (result_hi !== 32'd0)   begin nerr++; $display("FAIL reset_hi got %h want 0", result_hi); end
    ncmp++; if (result_lo !== 32'd0)   begin nerr++; $display("FAIL reset_lo got %h want 0", result_lo); end
    rst = 1'b0;
    @(posedge clk); #1;
    ncmp++; if (ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL idle_after_reset got ready=%b busy=%b want 1/0", ready, busy);
    end
  endtask

  task automatic test_multu_max();
    res_t e; int at_c; logic [31:0] h, l;
    e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001;
    exp_q.push_back(e);
    accept(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_strobe(at_c, h, l);
    e = pop_exp();
    ncmp++; if (at_c != 33) begin nerr++; $display("FAIL multu_latency got %0d want 33", at_c); end
    ncmp++; if (h !== e.hi) begin nerr++; $display("FAIL multu_hi got %h want %h", h, e.hi); end
    ncmp++; if (l !== e.lo) begin nerr++; $display("FAIL multu_lo got %h want %h", l, e.lo); end
    @(negedge clk);
    ncmp++; if (result_valid !== 1'b0) begin nerr++; $display("FAIL multu_strobe_width got %b at cycle 34 want 0", result_valid); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL multu_idle got busy=%b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult_signed();
    res_t e; int at_c; logic [31:0] h, l;
    e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFF1;
    exp_q.push_back(e);
    accept(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_strobe(at_c, h, l);
    e = pop_exp();
    ncmp++; if (at_c != 33) begin nerr++; $display("FAIL mult_latency got %0d want 33", at_c); end
    ncmp++; if ({h, l} !== {e.hi, e.lo}) begin nerr++; $display("FAIL mult_neg got %h_%h want %h_%h", h, l, e.hi, e.lo); end
  endtask

  task automatic test_random();
    res_t e; int at_c; logic [31:0] h, l, x, y; logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
`ifdef MDU_DIV_EN
      o = 2'($urandom_range(0, 3));
`else
      o = 2'($urandom_range(0, 1));
`endif
      x = $urandom;
      y = (i == 7) ? 32'd0 : $urandom;
      if (i == 3) x = 32'h8000_0001;
      exp_q.push_back(model(o, x, y));
      accept(o, x, y);
      wait_strobe(at_c, h, l);
      e = pop_exp();
      ncmp++; if (at_c != 33 || {h, l} !== {e.hi, e.lo}) begin
        nerr++; $display("FAIL random_%0d op=%0d a=%h b=%h got cyc=%0d %h_%h want cyc=33 %h_%h", i, o, x, y, at_c, h, l, e.hi, e.lo);
      end
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_divide();
    logic [1:0]  t_op[3] = '{MDU_DIV, MDU_DIVU, MDU_DIV};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] t_b[3]  = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] t_hi[3] = '{32'hFFFF_FFFF, 32'd7, 32'd0};
    logic [31:0] t_lo[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    res_t e; int at_c; logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      e.hi = t_hi[i]; e.lo = t_lo[i];
      exp_q.push_back(e);
      accept(t_op[i], t_a[i], t_b[i]);
      wait_strobe(at_c, h, l);
      e = pop_exp();
      ncmp++; if (at_c != 33) begin nerr++; $display("FAIL div_%0d_latency got %0d want 33", i, at_c); end
      ncmp++; if ({h, l} !== {e.hi, e.lo}) begin nerr++; $display("FAIL div_%0d got %h_%h want %h_%h", i, h, l, e.hi, e.lo); end
    end
  endtask
`else
  task automatic test_illegal();
    res_t e; int at_c; logic [31:0] h, l;
    start = 1'b1; op = MDU_DIV; a = 32'd7; b = 32'd2;
    @(negedge clk);
    ncmp++; if (stall !== 1'b0) begin nerr++; $display("FAIL illegal_stall got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    ncmp++; if (illegal_op !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL illegal_pulse got illegal=%b busy=%b want 1/0", illegal_op, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    ncmp++; if (illegal_op !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL illegal_width got illegal=%b busy=%b want 0/0", illegal_op, busy);
    end
    @(posedge clk); #1;
    e.hi = 32'd0; e.lo = 32'd12;
    exp_q.push_back(e);
    accept(MDU_MULTU, 32'd3, 32'd4);
    wait_strobe(at_c, h, l);
    e = pop_exp();
    ncmp++; if (at_c != 33 || {h, l} !== {e.hi, e.lo}) begin
      nerr++; $display("FAIL after_illegal got cyc=%0d %h_%h want cyc=33 %h_%h", at_c, h, l, e.hi, e.lo);
    end
  endtask
`endif

  task automatic test_mf_stall();
    res_t e; int bad, nv;
    bad = 0; nv = 0;
    exp_q.push_back(model(MDU_MULTU, 32'h0001_0003, 32'h0002_0005));
    accept(MDU_MULTU, 32'h0001_0003, 32'h0002_0005);
    for (int c = 1; c <= 34; c++) begin
      mf_req = (c >= 5);
      @(negedge clk);
      if (stall !== ((c >= 5 && c <= 33) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL mf_stall cycle %0d got %b", c, stall);
      end
      if (result_valid === 1'b1) begin
        nv++;
        e = pop_exp();
        ncmp++; if (c != 33 || {result_hi, result_lo} !== {e.hi, e.lo}) begin
          nerr++; $display("FAIL mf_result got cyc=%0d %h_%h want cyc=33 %h_%h", c, result_hi, result_lo, e.hi, e.lo);
        end
      end
      @(posedge clk); #1;
    end
    mf_req = 1'b0;
    ncmp++; if (bad != 0) begin nerr++; $display("FAIL mf_stall_window got %0d bad cycles want 0", bad); end
    ncmp++; if (nv != 1) begin nerr++; $display("FAIL mf_strobes got %0d want 1", nv); end
  endtask

  task automatic test_back_to_back();
    res_t e; int bad, nv, acc_c; int sc[2];
    bad = 0; nv = 0; acc_c = -1; sc[0] = -1; sc[1] = -1;
    exp_q.push_back(model(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000));
    accept(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) begin
        start = 1'b1; op = MDU_MULTU; a = 32'hDEAD_BEEF; b = 32'h0000_1001;
        exp_q.push_back(model(MDU_MULTU, 32'hDEAD_BEEF, 32'h0000_1001));
      end
      @(negedge clk);
      if (stall !== ((c >= 10 && c <= 32) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL b2b_stall cycle %0d got %b", c, stall);
      end
      if (result_valid === 1'b1) begin
        if (nv < 2) sc[nv] = c;
        nv++;
        e = pop_exp();
        ncmp++; if ({result_hi, result_lo} !== {e.hi, e.lo}) begin
          nerr++; $display("FAIL b2b_result_%0d got %h_%h want %h_%h", nv, result_hi, result_lo, e.hi, e.lo);
        end
      end
      if (start === 1'b1 && ready === 1'b1 && acc_c < 0) acc_c = c;
      @(posedge clk); #1;
      if (acc_c == c) start = 1'b0;
    end
    start = 1'b0;
    ncmp++; if (bad != 0) begin nerr++; $display("FAIL b2b_stall_window got %0d bad cycles want 0", bad); end
    ncmp++; if (acc_c != 33) begin nerr++; $display("FAIL b2b_accept got %0d want 33", acc_c); end
    ncmp++; if (nv != 2 || sc[0] != 33 || sc[1] != 66) begin
      nerr++; $display("FAIL b2b_strobes got n=%0d at %0d,%0d want 2 at 33,66", nv, sc[0], sc[1]);
    end
  endtask

  task automatic test_flush();
    int nv;
    nv = 0;
    accept(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int c = 1; c <= 45; c++) begin
      flush = (c == 10);
      @(negedge clk);
      if (result_valid === 1'b1) nv++;
      if (c == 10) begin
        ncmp++; if (busy !== 1'b1) begin nerr++; $display("FAIL flush_busy_c10 got %b want 1", busy); end
      end
      if (c == 11) begin
        ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL flush_busy_c11 got %b want 0", busy); end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    ncmp++; if (nv != 0) begin nerr++; $display("FAIL flush_strobe got %0d want 0", nv); end
    ncmp++; if ({result_hi, result_lo} !== {last_hi, last_lo}) begin
      nerr++; $display("FAIL flush_hilo got %h_%h want %h_%h", result_hi, result_lo, last_hi, last_lo);
    end
    start = 1'b1; flush = 1'b1; op = MDU_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL flush_start got busy=%b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int nv;
    nv = 0;
    accept(MDU_MULT, 32'hFFFF_0001, 32'h0000_7777);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    ncmp++; if ({busy, ready, stall, result_valid, illegal_op} !== 5'b01000) begin
      nerr++; $display("FAIL rst_mid_ctrl got busy/ready/stall/valid/illegal=%b want 01000", {busy, ready, stall, result_valid, illegal_op});
    end
    ncmp++; if ({result_hi, result_lo} !== 64'd0) begin
      nerr++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", result_hi, result_lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1 || busy === 1'b1) nv++;
      @(posedge clk); #1;
    end
    ncmp++; if (nv != 0) begin nerr++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", nv); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
`ifdef MDU_DIV_EN
    test_divide();
`else
    test_illegal();
`endif
    test_random();
    test_mf_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    ncmp++; if (exp_q.size() != 0) begin nerr++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide sequencer that owns the HI/LO-producing arithmetic for MULT/MULTU/DIV/DIVU. It sits beside the ALU in the execute stage and takes requests from decode alongside the HI/LO control fields. It runs a radix-2 shift-add / restoring-divide loop over 32 cycles and stalls the pipeline for dependent MFHI/MFLO or a second request. It returns one 64-bit result pulse to the HI/LO register file.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request, qualified by ready.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand: multiplicand or dividend.
- b  in  WIDTH  rt operand: multiplier or divisor.
- mf_req  in  1  decode holds MFHI/MFLO.
- flush  in  1  exception or abort.
- ready  out  1  a request can be accepted this cycle.
- busy  out  1  state is not IDLE.
- stall  out  1  freeze the upstream pipeline.
- result_valid  out  1  one-cycle HI/LO write strobe; drives HI/LO write-enable 11.
- result_hi  out  WIDTH  product[63:32] or remainder.
- result_lo  out  WIDTH  product[31:0] or quotient.
- illegal_op  out  1  one-cycle pulse for an unsupported op.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN: on start && !flush. At that point op is latched, |a| and |b| (signed ops) or raw values (unsigned ops) are latched, sign flags are captured, and the counter is cleared.
- RUN: performs one iteration per cycle.
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper accumulator, then shift right one.
  - Divide: shift remainder:quotient left one, trial-subtract the divisor, and restore on borrow.
- RUN→DONE: when counter == WIDTH-1.
- DONE: result_valid = !flush. Sign correction is applied to the results:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- DONE→RUN if start && !flush (back-to-back), otherwise DONE→IDLE.
- ready = (state==IDLE || state==DONE).
- stall = (mf_req && busy) || (start && state==RUN).
- Divide by zero runs the full 32 cycles. Result: result_lo = all ones, result_hi = a, for both signed and unsigned.
- 0x80000000 DIV 0xFFFFFFFF gives result_lo = 0x80000000, result_hi = 0.
- flush in RUN: next state is IDLE, no result, HI/LO untouched.
- flush together with start: flush wins and the request is dropped.
- result_hi/lo hold their last value until the next DONE.

## Timing
- Reset values: state IDLE; busy 0, ready 1, stall 0, result_valid 0, illegal_op 0, result_hi 0, result_lo 0.
- Latency: request accepted at edge 0; RUN covers cycles 1..32; DONE (result_valid) is cycle 33. Accept-to-strobe is 33 cycles.
- Throughput: one operation per 33 cycles when requests are back-to-back.
- MFHI/MFLO stall persists through the DONE cycle and releases in the next cycle, when HI/LO already holds the new value.
- Reset mid-operation: returns to IDLE immediately. No strobe is produced and outputs take their reset values.

## Configuration
- MDU_DIV_EN defined: divide datapath and sign correction are present; illegal_op is tied 0.
- MDU_DIV_EN undefined: divide logic is removed.
  - start with op 10/11 is not accepted: FSM stays in place, no stall is raised, and illegal_op pulses for one cycle.
  - MULT/MULTU behaviour is unchanged.

## Structure
- mdu_pkg holds the op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), the state enum, and the WIDTH default.
- Sub-module mdu_iter_core holds the per-cycle add/shift and subtract/restore step on the 64-bit accumulator. It is purely combinational, selected by a mul/div bit.
- mdu_ctrl owns the FSM, counter, operand/sign registers, and output registers.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → cycle 33: result_hi=0xFFFFFFFE, result_lo=0x00000001, result_valid high for exactly 1 cycle.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Separately, DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7 after 33 cycles. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mf_req raised at cycle 5 → stall high through cycle 33, low at cycle 34. A second start at cycle 10 → stall high until accepted at cycle 33; its result arrives at cycle 66.
- flush at cycle 10 → no result_valid, busy low at cycle 11. rst at cycle 20 of a new operation → all outputs at reset values immediately.
- Build without MDU_DIV_EN: start with op=DIV → illegal_op pulses for 1 cycle, busy stays 0, and a following MULTU 3×4 → lo=12, hi=0.
